dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4: consecutive lost arbitrations after which port 1 is forced to win.
REQ-002 Parameter RR_MODE, default 0: 0 gives fixed port-0 priority plus the starvation guard; 1 gives round-robin.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req0/req1  in  1  access request from port 0 (CPU load/store) and port 1 (debug/DMA); held high until the matching ack.
REQ-006 we0/we1  in  1  1 = write, 0 = read; valid while req is high.
REQ-007 addr0/addr1  in  32  byte address; valid while req is high.
REQ-008 wdata0/wdata1  in  32  write data; valid while req is high.
REQ-009 ack0/ack1  out  1  one-cycle completion pulse.
REQ-010 err0/err1  out  1  misaligned-access flag; valid only with the matching ack.
REQ-011 rdata  out  32  read data; valid with any ack on a read.
REQ-012 mem_we  out  1  data-memory write enable.
REQ-013 mem_a  out  32  data-memory address.
REQ-014 mem_wd  out  32  data-memory write data.
REQ-015 mem_rd  in  32  data-memory read data; combinational from mem_a.

Function
REQ-016 The FSM SHALL have three states: IDLE, BUSY, RESP.
REQ-017 In IDLE with any req high, the arbiter SHALL pick a winner, latch its we/addr/wdata and port id, then go to BUSY; if the address is aligned, or to RESP with err set if addr[1:0] != 0.
REQ-018 In BUSY the arbiter SHALL drive mem_a/mem_wd from the latched values and assert mem_we = latched we, for exactly one cycle.
REQ-019 At the edge ending BUSY, rdata SHALL capture mem_rd, and the FSM SHALL go to RESP.
REQ-020 In RESP, only the winner's ack SHALL be high, for one cycle; the FSM SHALL then return to IDLE unconditionally.
REQ-021 Latency: with req sampled at edge k, ack SHALL be high during cycle k+2 (aligned) or k+1 (misaligned); maximum throughput is one access per 3 cycles.
REQ-022 mem_we SHALL be 0 in every state other than BUSY; a misaligned access SHALL never touch memory.
REQ-023 In RR_MODE=0, port 0 SHALL win simultaneous requests unless wait1 == MAX_WAIT, in which case port 1 SHALL win.
REQ-024 wait1 SHALL saturate at MAX_WAIT.
REQ-025 wait1 SHALL increment when port 0 is granted while req1 is high.
REQ-026 wait1 SHALL clear when port 1 is granted or req1 is low in IDLE.
REQ-027 In RR_MODE=1, on simultaneous requests the port not granted last SHALL win; last-grant SHALL reset to port 1, so port 0 wins the first tie.
REQ-028 A single requesting port SHALL always win, regardless of mode or counters.
REQ-029 For a write, rdata SHALL hold the memory's pre-write content at that address.
REQ-030 err SHALL be 0 on every aligned access.
REQ-031 A req dropped before ack SHALL NOT abort an access already latched; the ack SHALL still pulse.

Reset
REQ-032 On rst_n low, the block SHALL asynchronously set FSM=IDLE, ack0/ack1/err0/err1/mem_we=0, rdata/mem_a/mem_wd=0, wait1=0 and last-grant=port 1.
REQ-033 Reset asserted in BUSY SHALL drop mem_we in the same cycle, and no ack SHALL follow.
REQ-034 After rst_n rises, the first arbitration SHALL occur at the first rising edge with rst_n high.

Structure
REQ-035 State encodings (IDLE=2'd0, BUSY=2'd1, RESP=2'd2) and port ids SHALL live in the shared package mips_mem_pkg.
REQ-036 The winner-select logic SHALL be one combinational sub-module, dmem_arb_pick: inputs req0, req1, wait1, last-grant, RR_MODE; output the winner id.
REQ-037 The dataMemory instance SHALL stay outside this block and connect through the mem_* ports.

Verification
REQ-038 Port 0 writes 32'hdeadbeef to addr 4, then port 1 reads addr 4 -> ack1 in cycle k+2 with rdata = 32'hdeadbeef, err1 = 0.
REQ-039 req0 and req1 both held high in RR_MODE=0 with MAX_WAIT=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1.
REQ-040 req0 and req1 both held high in RR_MODE=1 -> grants alternate 0,1,0,1.
REQ-041 Port 1 writes addr 32'h6 -> ack1 with err1 = 1 at cycle k+1, mem_we never high, addr 4 content unchanged.
REQ-042 rst_n pulsed low during BUSY of a write to addr 8 with data 32'h12345678 -> mem_we falls immediately, no ack, memory at 8 unchanged; FSM in IDLE after release.
REQ-043 Port 0 writes 32'h1 to addr 12 then reads addr 12 -> the write ack returns the old value; the read ack returns 32'h1.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types for the data-memory arbiter: FSM state encodings and port ids.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner select for the data-memory arbiter: fixed priority with a starvation
// guard for port 1, or round-robin on ties.
module dmem_arb_pick
  import mips_mem_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WW       = 3
) (
  input  logic          req0,
  input  logic          req1,
  input  logic [WW-1:0] wait1,
  input  port_t         last_grant,
  input  logic          rr_mode,
  output port_t         winner
);

  always_comb begin
    winner = PORT0;
    if (req1 && !req0) begin
      winner = PORT1;
    end else if (req0 && req1) begin
      if (rr_mode) winner = (last_grant == PORT0) ? PORT1 : PORT0;
      else if (wait1 == WW'(MAX_WAIT)) winner = PORT1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory. One access per
// three cycles: IDLE (arbitrate) -> BUSY (memory cycle) -> RESP (ack pulse).
module dmem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int RR_MODE  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  state_t        state;
  port_t         winner;
  port_t         last_grant;
  port_t         cur_port;
  logic [WW-1:0] wait1;
  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;

  dmem_arb_pick #(
    .MAX_WAIT (MAX_WAIT),
    .WW       (WW)
  ) u_pick (
    .req0       (req0),
    .req1       (req1),
    .wait1      (wait1),
    .last_grant (last_grant),
    .rr_mode    (RR_MODE != 0),
    .winner     (winner)
  );

  always_comb begin
    sel_we    = (winner == PORT1) ? we1    : we0;
    sel_addr  = (winner == PORT1) ? addr1  : addr0;
    sel_wdata = (winner == PORT1) ? wdata1 : wdata0;
  end

  // mem_a/mem_wd/mem_we double as the latched request; a misaligned access
  // skips them so memory is never touched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata      <= '0;
      mem_we     <= 1'b0;
      mem_a      <= '0;
      mem_wd     <= '0;
      wait1      <= '0;
      last_grant <= PORT1;
      cur_port   <= PORT0;
    end else begin
      case (state)
        IDLE: begin
          if (!req1) wait1 <= '0;
          if (req0 || req1) begin
            last_grant <= winner;
            cur_port   <= winner;
            if (winner == PORT1) wait1 <= '0;
            else if (req1 && wait1 != WW'(MAX_WAIT)) wait1 <= wait1 + 1'b1;
            if (misaligned(sel_addr)) begin
              state <= RESP;
              ack0  <= (winner == PORT0);
              ack1  <= (winner == PORT1);
              err0  <= (winner == PORT0);
              err1  <= (winner == PORT1);
            end else begin
              state  <= BUSY;
              mem_we <= sel_we;
              mem_a  <= sel_addr;
              mem_wd <= sel_wdata;
            end
          end
        end
        BUSY: begin
          rdata  <= mem_rd;
          mem_we <= 1'b0;
          state  <= RESP;
          ack0   <= (cur_port == PORT0);
          ack1   <= (cur_port == PORT1);
          err0   <= 1'b0;
          err1   <= 1'b0;
        end
        RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err0  <= 1'b0;
          err1  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a fixed-priority and a round-robin instance,
// each with its own behavioural data memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;

  logic        fp_ack0, fp_ack1, fp_err0, fp_err1, fp_mem_we;
  logic [31:0] fp_rdata, fp_mem_a, fp_mem_wd, fp_mem_rd;
  logic        rr_ack0, rr_ack1, rr_err0, rr_err1, rr_mem_we;
  logic [31:0] rr_rdata, rr_mem_a, rr_mem_wd, rr_mem_rd;

  logic [31:0] mem_fp [64];
  logic [31:0] mem_rr [64];
  logic        mem_init = 1'b0;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;

  dmem_arbiter #(.MAX_WAIT(4), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(fp_ack0), .ack1(fp_ack1), .err0(fp_err0), .err1(fp_err1),
    .rdata(fp_rdata), .mem_we(fp_mem_we), .mem_a(fp_mem_a), .mem_wd(fp_mem_wd),
    .mem_rd(fp_mem_rd)
  );

  dmem_arbiter #(.MAX_WAIT(4), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(rr_ack0), .ack1(rr_ack1), .err0(rr_err0), .err1(rr_err1),
    .rdata(rr_rdata), .mem_we(rr_mem_we), .mem_a(rr_mem_a), .mem_wd(rr_mem_wd),
    .mem_rd(rr_mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fp_mem_rd = mem_fp[fp_mem_a[7:2]];
  assign rr_mem_rd = mem_rr[rr_mem_a[7:2]];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem_fp[i] <= 32'ha000_0000 + 32'(i);
        mem_rr[i] <= 32'ha000_0000 + 32'(i);
      end
      mem_init <= 1'b1;
    end else begin
      if (fp_mem_we) mem_fp[fp_mem_a[7:2]] <= fp_mem_wd;
      if (rr_mem_we) mem_rr[rr_mem_a[7:2]] <= rr_mem_wd;
    end
  end

  always @(posedge clk) if (fp_mem_we) we_cnt = we_cnt + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Issue one access on one port; lat = edges from the sampling edge to ack (0 = timeout).
  task automatic run_access(input logic port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, output int lat, output logic [31:0] rd,
                            output logic err, output logic wrong_ack);
    @(negedge clk);
    we_cnt = 0;
    lat = 0; rd = '0; err = 1'b0; wrong_ack = 1'b0;
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (port ? fp_ack0 : fp_ack1) wrong_ack = 1'b1;
      if (port ? fp_ack1 : fp_ack0) begin
        lat = c;
        rd  = fp_rdata;
        err = port ? fp_err1 : fp_err0;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
    int          wes;
  } vec_t;

  vec_t vecs[9];
  int   exp_fp[10];

  initial begin
    int          lat, nfp, nrr, first_c, acks;
    logic [31:0] rd;
    logic        err, wrong;

    vecs[0] = '{1'b0, 1'b1, 32'h4,  32'hdeadbeef, 2, 1'b0, 1'b1, 32'ha000_0001, 1};
    vecs[1] = '{1'b1, 1'b0, 32'h4,  32'h0,        2, 1'b0, 1'b1, 32'hdeadbeef, 0};
    vecs[2] = '{1'b1, 1'b1, 32'h6,  32'hbad0bad0, 1, 1'b1, 1'b0, 32'h0,        0};
    vecs[3] = '{1'b0, 1'b0, 32'h4,  32'h0,        2, 1'b0, 1'b1, 32'hdeadbeef, 0};
    vecs[4] = '{1'b0, 1'b1, 32'hc,  32'h1,        2, 1'b0, 1'b1, 32'ha000_0003, 1};
    vecs[5] = '{1'b0, 1'b0, 32'hc,  32'h0,        2, 1'b0, 1'b1, 32'h1,        0};
    vecs[6] = '{1'b0, 1'b0, 32'h1,  32'h0,        1, 1'b1, 1'b0, 32'h0,        0};
    vecs[7] = '{1'b1, 1'b1, 32'h20, 32'h55aa55aa, 2, 1'b0, 1'b1, 32'ha000_0008, 1};
    vecs[8] = '{1'b1, 1'b0, 32'h20, 32'h0,        2, 1'b0, 1'b1, 32'h55aa55aa, 0};
    exp_fp = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {30'd0, fp_ack1, fp_ack0}, 32'd0);
    check("rst_err", {30'd0, fp_err1, fp_err0}, 32'd0);
    check("rst_mem_we", {31'd0, fp_mem_we}, 32'd0);
    check("rst_rdata", fp_rdata, 32'd0);
    check("rst_mem_a", fp_mem_a, 32'd0);
    check("rst_mem_wd", fp_mem_wd, 32'd0);

    // Both ports held high from the first edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'h10; addr1 = 32'h14;
    nfp = 0; nrr = 0; first_c = 0;
    for (int c = 1; c <= 60 && (nfp < 10 || nrr < 10); c++) begin
      @(posedge clk); #1;
      if ((fp_ack0 || fp_ack1) && nfp < 10) begin
        if (nfp == 0) first_c = c;
        check($sformatf("fp_grant%0d", nfp), {31'd0, fp_ack1}, 32'(exp_fp[nfp]));
        nfp++;
      end
      if ((rr_ack0 || rr_ack1) && nrr < 10) begin
        check($sformatf("rr_grant%0d", nrr), {31'd0, rr_ack1}, 32'(nrr % 2));
        nrr++;
      end
    end
    check("fp_grant_count", 32'(nfp), 32'd10);
    check("rr_grant_count", 32'(nrr), 32'd10);
    check("first_ack_latency", 32'(first_c), 32'd2);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      run_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wd, lat, rd, err, wrong);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
      check($sformatf("v%0d_other_ack", i), {31'd0, wrong}, 32'd0);
      check($sformatf("v%0d_mem_we_cycles", i), 32'(we_cnt), 32'(vecs[i].wes));
      if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
    end
    check("addr4_after_misaligned", mem_fp[1], 32'hdeadbeef);

    // Reset pulse in the middle of a write's BUSY cycle.
    @(negedge clk);
    we_cnt = 0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h12345678;
    @(posedge clk); #1;
    check("busy_mem_we", {31'd0, fp_mem_we}, 32'd1);
    req0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_drops_mem_we", {31'd0, fp_mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (fp_ack0 || fp_ack1) acks++;
    end
    check("no_ack_after_rst", 32'(acks), 32'd0);
    check("no_write_after_rst", 32'(we_cnt), 32'd0);
    check("addr8_unchanged", mem_fp[2], 32'ha000_0002);
    run_access(1'b0, 1'b0, 32'h8, 32'h0, lat, rd, err, wrong);
    check("post_rst_latency", 32'(lat), 32'd2);
    check("post_rst_rdata", rd, 32'ha000_0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
